wb_unit: RTL and testbench
==========================

# wb_unit

Writeback stage of the 16-bit, 8-register pipeline. It accepts one retiring instruction per handshake from the memory stage and waits for load data when needed. It then presents exactly one cycle of `wreg`/`wd`/`skip` to the register-file read/write unit directly downstream. It also tracks a load timeout and a retire count.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles spent in WAIT_MEM before the load is abandoned (1..255).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: memory stage presents an instruction.
- `in_ready`  out  1: stage can accept this cycle.
- `in_wreg`  in  3: destination register.
- `in_wsel`  in  2: result source: 00 ALU, 01 MEM, 10 LINK, 11 NONE (no write).
- `in_alu`  in  16: ALU result.
- `in_link`  in  16: link value (PC+1).
- `mem_rvalid`  in  1: load data valid.
- `mem_rdata`  in  16: load data.
- `wreg`  out  3: write register to register-file unit.
- `wd`  out  16: write data.
- `skip`  out  1: 1 = no write this cycle.
- `fwd_valid`  out  1: forwarding entry valid.
- `fwd_reg`  out  3: forwarded register.
- `fwd_data`  out  16: forwarded value.
- `timeout_err`  out  1: sticky load-timeout flag.
- `retired`  out  16: count of committed writes.

## Operation
- States: IDLE, WAIT_MEM, COMMIT. All outputs are registered.
- Accept occurs when `in_valid && in_ready`. `in_ready` = 1 in IDLE and COMMIT, and 0 in WAIT_MEM.
- On accept, capture `in_wreg` and `in_wsel`.
- wsel ALU or LINK: capture the selected value and go to COMMIT.
- wsel NONE: go to COMMIT with `skip` held at 1.
- wsel MEM with `mem_rvalid` high in the same cycle: capture `mem_rdata` and go to COMMIT.
- wsel MEM with `mem_rvalid` low: go to WAIT_MEM and clear the timeout counter.
- WAIT_MEM, `mem_rvalid` high: capture `mem_rdata` and go to COMMIT.
- WAIT_MEM, otherwise: increment the counter. When the counter reaches `TIMEOUT`, set `timeout_err` and go to COMMIT with `skip` = 1, so the abandoned write is dropped.
- COMMIT lasts exactly one cycle, with `skip` = 0 unless wsel is NONE or the load was abandoned. From COMMIT, go to the next state per the accept rules if a new accept occurs, else go to IDLE. Back-to-back ALU ops commit every cycle.
- `skip` = 1 in IDLE and WAIT_MEM.
- `mem_rvalid` outside WAIT_MEM and outside a MEM accept is ignored.
- `retired` increments on each COMMIT with `skip` = 0 and wraps from 0xFFFF to 0.
- `timeout_err` clears only on `rst`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `skip` 1, `wreg` 0, `wd` 0, `fwd_valid` 0, `fwd_reg` 0, `fwd_data` 0, `timeout_err` 0, `retired` 0.
- ALU, LINK, or MEM-with-rvalid accept in cycle N: `skip` = 0 with data in cycle N+1. The register file writes at the end of cycle N+1.
- MEM accept at N, `mem_rvalid` at N+k: commit at N+k+1.
- Timeout: `timeout_err` rises in the cycle entering COMMIT, i.e. TIMEOUT+1 cycles after the accept.
- `rst` mid-WAIT_MEM or mid-COMMIT: the pending write is discarded and `skip` = 1 in the next cycle.

## Configuration
- `WB_FWD_EN` defined: `fwd_valid` = 1 exactly in write-enabled COMMIT cycles, with `fwd_reg` = `wreg` and `fwd_data` = `wd`.
- `WB_FWD_EN` undefined: `fwd_valid`, `fwd_reg`, and `fwd_data` are tied to 0. The ports remain.

## Structure
- `wb_pkg` holds:
  - the wsel encodings WSEL_ALU, WSEL_MEM, WSEL_LINK, WSEL_NONE;
  - the state encodings;
  - the register-address width (3) and data width (16).
- One sub-module, `wb_timeout_ctr`, provides the clear/increment counter with a terminal-count output at `TIMEOUT`.

## Test plan
- Reset, then accept ALU op wreg=3, alu=0x1234 -> next cycle `skip`=0, `wreg`=3, `wd`=0x1234, `retired`=1.
- Three back-to-back ALU ops, one per cycle -> three consecutive commit cycles and `in_ready` held at 1.
- MEM op wreg=5, `mem_rvalid` after 4 cycles with 0xBEEF -> `in_ready`=0 while waiting, commit 1 cycle after rvalid with `wd`=0xBEEF.
- MEM op with no rvalid, TIMEOUT=15 -> `timeout_err`=1 and `skip`=1 at the 16th cycle after accept, `retired` unchanged.
- wsel NONE op, then `rst` asserted during WAIT_MEM of a following MEM op -> no write ever, all outputs at reset values.
- With `WB_FWD_EN`, LINK op wreg=7, link=0x0042 -> `fwd_valid`=1, `fwd_reg`=7, `fwd_data`=0x0042 for exactly one cycle. Without `WB_FWD_EN` -> `fwd_valid`=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings and widths for the writeback stage of the 16-bit, 8-register pipeline.
package wb_pkg;
    localparam int REG_W  = 3;
    localparam int DATA_W = 16;
    localparam int CTR_W  = 8;

    typedef enum logic [1:0] {
        WSEL_ALU  = 2'b00,
        WSEL_MEM  = 2'b01,
        WSEL_LINK = 2'b10,
        WSEL_NONE = 2'b11
    } wsel_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_e;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Load-wait counter: clear on a waiting MEM accept, increment per idle wait cycle.
module wb_timeout_ctr
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    logic [CTR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // hit fires on the increment that makes the count reach TIMEOUT
    assign hit = inc && (count == CTR_W'(TIMEOUT - 1));
endmodule

// File: rtl/wb_unit.sv
// Writeback stage: accept one retiring instruction, wait for load data, commit one cycle.
// Optional forwarding port contents enabled by defining WB_FWD_EN.
module wb_unit
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic [1:0]        in_wsel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_link,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [REG_W-1:0]  wreg,
    output logic [DATA_W-1:0] wd,
    output logic              skip,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              timeout_err,
    output logic [15:0]       retired
);
    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready is registered and low only while waiting for load data.
    state_e            state;
    logic [DATA_W-1:0] sel_data;
    logic              acc_wait;
    logic              acc_write;
    logic              tc_clr;
    logic              tc_inc;
    logic              tc_hit;

    always_comb begin
        sel_data = mem_rdata;
        case (wsel_e'(in_wsel))
            WSEL_ALU:  sel_data = in_alu;
            WSEL_LINK: sel_data = in_link;
            default:   sel_data = mem_rdata;
        endcase
    end

    assign acc_wait  = (in_wsel == WSEL_MEM) && !mem_rvalid;
    assign acc_write = (in_wsel != WSEL_NONE) && !acc_wait;
    assign tc_clr    = in_valid && in_ready && acc_wait;
    assign tc_inc    = (state == WAIT_MEM) && !mem_rvalid;

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk (clk),
        .rst (rst),
        .clr (tc_clr),
        .inc (tc_inc),
        .hit (tc_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            skip        <= 1'b1;
            wreg        <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
            retired     <= '0;
`ifdef WB_FWD_EN
            fwd_valid   <= 1'b0;
            fwd_reg     <= '0;
            fwd_data    <= '0;
`endif
        end else begin
            skip <= 1'b1;
`ifdef WB_FWD_EN
            fwd_valid <= 1'b0;
`endif
            case (state)
                IDLE, COMMIT: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    if (in_valid) begin
                        wreg <= in_wreg;
                        if (acc_wait) begin
                            state    <= WAIT_MEM;
                            in_ready <= 1'b0;
                        end else begin
                            state <= COMMIT;
                            if (acc_write) begin
                                skip    <= 1'b0;
                                wd      <= sel_data;
                                retired <= retired + 16'd1;
`ifdef WB_FWD_EN
                                fwd_valid <= 1'b1;
                                fwd_reg   <= in_wreg;
                                fwd_data  <= sel_data;
`endif
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state    <= COMMIT;
                        in_ready <= 1'b1;
                        skip     <= 1'b0;
                        wd       <= mem_rdata;
                        retired  <= retired + 16'd1;
`ifdef WB_FWD_EN
                        fwd_valid <= 1'b1;
                        fwd_reg   <= wreg;
                        fwd_data  <= mem_rdata;
`endif
                    end else if (tc_hit) begin
                        // abandoned load: commit slot with the write dropped
                        state       <= COMMIT;
                        in_ready    <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifndef WB_FWD_EN
    assign fwd_valid = 1'b0;
    assign fwd_reg   = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios plus randomized transactions against a transaction-level model.
module tb_wb_unit;
    import wb_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_wreg;
    logic [1:0]  in_wsel;
    logic [15:0] in_alu;
    logic [15:0] in_link;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [2:0]  wreg;
    logic [15:0] wd;
    logic        skip;
    logic        fwd_valid;
    logic [2:0]  fwd_reg;
    logic [15:0] fwd_data;
    logic        timeout_err;
    logic [15:0] retired;

    wb_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wreg     (in_wreg),
        .in_wsel     (in_wsel),
        .in_alu      (in_alu),
        .in_link     (in_link),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wreg        (wreg),
        .wd          (wd),
        .skip        (skip),
        .fwd_valid   (fwd_valid),
        .fwd_reg     (fwd_reg),
        .fwd_data    (fwd_data),
        .timeout_err (timeout_err),
        .retired     (retired)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [19:0] exp_q[$];          // {skip, wreg, wd} expected in the next commit cycle
    logic [15:0] exp_retired = 16'd0;
    logic        exp_terr    = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sched(input logic s, input logic [2:0] r, input logic [15:0] d);
        exp_q.push_back({s, r, d});
        if (!s) exp_retired++;
    endtask

    task automatic check_reset();
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_skip", 16'(skip), 16'd1);
        chk("rst_wreg", 16'(wreg), 16'd0);
        chk("rst_wd", wd, 16'd0);
        chk("rst_fwd_valid", 16'(fwd_valid), 16'd0);
        chk("rst_fwd_reg", 16'(fwd_reg), 16'd0);
        chk("rst_fwd_data", fwd_data, 16'd0);
        chk("rst_timeout_err", 16'(timeout_err), 16'd0);
        chk("rst_retired", retired, 16'd0);
    endtask

    // scoreboard: compare this cycle's outputs against the model
    task automatic check_cycle();
        logic [19:0] e;
        logic        exp_fv;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 3'd0, 16'd0};
        exp_fv = 1'b0;
        chk("skip", 16'(skip), 16'(e[19]));
        if (!e[19]) begin
            chk("wreg", 16'(wreg), 16'(e[18:16]));
            chk("wd", wd, e[15:0]);
`ifdef WB_FWD_EN
            exp_fv = 1'b1;
            chk("fwd_reg", 16'(fwd_reg), 16'(e[18:16]));
            chk("fwd_data", fwd_data, e[15:0]);
`endif
        end
`ifndef WB_FWD_EN
        chk("fwd_reg_tied", 16'(fwd_reg), 16'd0);
        chk("fwd_data_tied", fwd_data, 16'd0);
`endif
        chk("fwd_valid", 16'(fwd_valid), 16'(exp_fv));
        chk("retired", retired, exp_retired);
        chk("timeout_err", 16'(timeout_err), 16'(exp_terr));
    endtask

    // driver: one transaction; k = cycles after accept until rvalid (0 = with accept, >TIMEOUT = never)
    task automatic run_op(input logic [1:0] ws, input logic [2:0] r, input logic [15:0] alu,
                          input logic [15:0] link, input logic [15:0] rdata, input int k);
        chk("in_ready_accept", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_wsel  = ws;
        in_wreg  = r;
        in_alu   = alu;
        in_link  = link;
        if (ws == WSEL_MEM) begin
            mem_rvalid = (k == 0);
            mem_rdata  = (k == 0) ? rdata : 16'($urandom);
        end else begin
            mem_rvalid = 1'($urandom);
            mem_rdata  = 16'($urandom);
        end
        step();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        in_wsel    = 2'($urandom);
        in_alu     = 16'($urandom);
        in_link    = 16'($urandom);
        if (ws == WSEL_MEM && k > 0) begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                check_cycle();
                chk("in_ready_wait", 16'(in_ready), 16'd0);
                mem_rdata = 16'($urandom);
                if (i == k) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                    step();
                    mem_rvalid = 1'b0;
                    sched(1'b0, r, rdata);
                    return;
                end else if (i == TIMEOUT) begin
                    step();
                    exp_terr = 1'b1;
                    sched(1'b1, r, 16'd0);
                    return;
                end
                step();
            end
        end else if (ws == WSEL_NONE) begin
            sched(1'b1, r, 16'd0);
        end else if (ws == WSEL_ALU) begin
            sched(1'b0, r, alu);
        end else if (ws == WSEL_LINK) begin
            sched(1'b0, r, link);
        end else begin
            sched(1'b0, r, rdata);
        end
    endtask

    initial begin
        logic [1:0] ws;
        int         kr;
        int         k;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_wreg    = 3'd0;
        in_wsel    = 2'd0;
        in_alu     = 16'd0;
        in_link    = 16'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'd0;
        step();
        step();
        check_reset();
        rst = 1'b0;
        step();
        check_cycle();

        // single ALU op
        run_op(WSEL_ALU, 3'd3, 16'h1234, 16'h0000, 16'h0000, 0);
        check_cycle();

        // three back-to-back ALU ops
        run_op(WSEL_ALU, 3'd1, 16'hA001, 16'h0, 16'h0, 0);
        check_cycle();
        run_op(WSEL_ALU, 3'd2, 16'hA002, 16'h0, 16'h0, 0);
        check_cycle();
        run_op(WSEL_ALU, 3'd4, 16'hA003, 16'h0, 16'h0, 0);
        check_cycle();
        step();
        check_cycle();

        // load with data 4 cycles after accept
        run_op(WSEL_MEM, 3'd5, 16'h0, 16'h0, 16'hBEEF, 4);
        check_cycle();

        // LINK op (forwarded when enabled)
        run_op(WSEL_LINK, 3'd7, 16'h0, 16'h0042, 16'h0, 0);
        check_cycle();
        step();
        check_cycle();

        // load abandoned after TIMEOUT
        run_op(WSEL_MEM, 3'd6, 16'h0, 16'h0, 16'h5555, TIMEOUT + 1);
        check_cycle();

        // NONE op, then reset in the middle of a load wait
        run_op(WSEL_NONE, 3'd2, 16'h7777, 16'h8888, 16'h0, 0);
        check_cycle();
        in_valid   = 1'b1;
        in_wsel    = WSEL_MEM;
        in_wreg    = 3'd1;
        mem_rvalid = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        exp_q.delete();
        exp_retired = 16'd0;
        exp_terr    = 1'b0;
        check_reset();
        rst = 1'b0;
        step();
        check_cycle();

        // randomized transactions with idle gaps and stray rvalid noise
        for (int n = 0; n < 300; n++) begin
            check_cycle();
            if ($urandom_range(0, 3) == 0) begin
                in_valid   = 1'b0;
                mem_rvalid = 1'($urandom);
                mem_rdata  = 16'($urandom);
                step();
                mem_rvalid = 1'b0;
            end else begin
                ws = 2'($urandom_range(0, 3));
                kr = $urandom_range(0, 9);
                if (kr < 3)      k = 0;
                else if (kr < 8) k = $urandom_range(1, TIMEOUT - 1);
                else if (kr == 8) k = TIMEOUT;
                else             k = TIMEOUT + 1;
                run_op(ws, 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), k);
            end
        end
        check_cycle();
        step();
        check_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
